// File: rtl/bridge_rx_pkg.sv
// bridge_rx_pkg: shared state type, default parameters and width helper for the bridge receive sink
package bridge_rx_pkg;
  typedef enum logic {IDLE, ACK} rx_state_t;
  localparam int DW_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int TIMEOUT_DEF = 64;
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/bridge_rx_fifo.sv
// bridge_rx_fifo: synchronous first-word-fall-through FIFO with occupancy level
module bridge_rx_fifo import bridge_rx_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int LW = lvl_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic [LW-1:0] level
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign valid   = level != '0;
  assign do_pop  = pop && valid;
  assign do_push = push && level != LW'(DEPTH);
  assign dout    = mem[rd_ptr];
  // pointers are exactly log2(DEPTH) bits, so they wrap without compare logic
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
endmodule

// File: rtl/bridge_rx_sink.sv
// bridge_rx_sink: receive-side 4-phase accept FSM feeding a FWFT FIFO on a valid/ready stream.
// Optional ACK timeout with sticky timeout_err when RX_SINK_TIMEOUT_EN is defined.
module bridge_rx_sink import bridge_rx_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int LW = lvl_w(DEPTH)
) (
  input  logic          clk2,
  input  logic          rst,
  input  logic          do_rdy_in,
  input  logic [DW-1:0] data_in,
  output logic          do_acpt_out,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
`ifdef RX_SINK_TIMEOUT_EN
  output logic          timeout_err,
`endif
  output logic [LW-1:0] fifo_level
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("bridge_rx_sink: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end
  rx_state_t state;
  logic full, cap, pop, blocked;
  assign full = fifo_level == LW'(DEPTH);
  assign cap  = state == IDLE && do_rdy_in && !full && !blocked;
  assign pop  = m_valid && m_ready;
`ifdef RX_SINK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic wait_low;
  assign blocked = wait_low;
  // after a timeout the same ready episode must not be captured again
  always_ff @(posedge clk2)
    if (rst) begin
      state       <= IDLE;
      do_acpt_out <= 1'b0;
      cnt         <= '0;
      wait_low    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (!do_rdy_in) wait_low <= 1'b0;
      if (state == IDLE) begin
        if (cap) begin
          state       <= ACK;
          do_acpt_out <= 1'b1;
          cnt         <= '0;
        end
      end else if (!do_rdy_in) begin
        state       <= IDLE;
        do_acpt_out <= 1'b0;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        state       <= IDLE;
        do_acpt_out <= 1'b0;
        timeout_err <= 1'b1;
        wait_low    <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
`else
  assign blocked = 1'b0;
  always_ff @(posedge clk2)
    if (rst) begin
      state       <= IDLE;
      do_acpt_out <= 1'b0;
    end else if (state == IDLE) begin
      if (cap) begin
        state       <= ACK;
        do_acpt_out <= 1'b1;
      end
    end else if (!do_rdy_in) begin
      state       <= IDLE;
      do_acpt_out <= 1'b0;
    end
`endif
  bridge_rx_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk2),
    .rst(rst),
    .push(cap),
    .pop(pop),
    .din(data_in),
    .dout(m_data),
    .valid(m_valid),
    .level(fifo_level)
  );
endmodule

// File: tb/tb_bridge_rx_sink.sv
// tb_bridge_rx_sink: directed and random checks of bridge_rx_sink against a queue-based model
module tb_bridge_rx_sink;
  localparam int DEPTH = 4;
  localparam int TO = 8;
  logic clk2 = 1'b0, rst = 1'b1, do_rdy_in = 1'b0, m_ready = 1'b0;
  logic [7:0] data_in = '0;
  logic do_acpt_out, m_valid;
  logic [7:0] m_data;
  logic [2:0] fifo_level;
`ifdef RX_SINK_TIMEOUT_EN
  logic timeout_err;
`endif
  int total = 0, bad = 0;
  logic [7:0] q[$];
  bit ack, werr, wlow;
  int acnt;
  always #5 clk2 = ~clk2;
  bridge_rx_sink #(.DW(8), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk2(clk2),
    .rst(rst),
    .do_rdy_in(do_rdy_in),
    .data_in(data_in),
    .do_acpt_out(do_acpt_out),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
`ifdef RX_SINK_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .fifo_level(fifo_level)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // one clock edge of the handshake rules: accept follows a capture, drops with ready
  task automatic model_step();
    bit pop, cap;
    if (rst) begin
      q.delete();
      ack = 0; acnt = 0; wlow = 0; werr = 0;
      return;
    end
    pop = q.size() != 0 && m_ready;
    cap = !ack && do_rdy_in && q.size() < DEPTH && !wlow;
    if (!do_rdy_in) wlow = 0;
    if (pop) q.delete(0);
    if (cap) q.push_back(data_in);
    if (cap) begin
      ack = 1; acnt = 0;
    end else if (ack && !do_rdy_in) begin
      ack = 0;
    end else if (ack) begin
      acnt++;
`ifdef RX_SINK_TIMEOUT_EN
      if (acnt == TO) begin
        ack = 0; werr = 1; wlow = 1;
      end
`endif
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) begin
      model_step();
      @(posedge clk2);
      #1;
      chk("acpt", do_acpt_out, ack);
      chk("valid", m_valid, q.size() != 0);
      chk("level", fifo_level, q.size());
      if (q.size() != 0) chk("data", m_data, q[0]);
`ifdef RX_SINK_TIMEOUT_EN
      chk("terr", timeout_err, werr);
`endif
    end
  endtask
  task automatic xfer(input logic [7:0] d);
    data_in = d; do_rdy_in = 1; cyc(2);
    do_rdy_in = 0; cyc(1);
  endtask
  initial begin
    cyc(2);
    chk("rst_data", m_data, 8'h00);
    rst = 0; cyc(1);
    // single transfer
    data_in = 8'hA5; do_rdy_in = 1; cyc(1);
    chk("single_acpt", do_acpt_out, 1);
    chk("single_data", m_data, 8'hA5);
    cyc(1);
    do_rdy_in = 0; cyc(1);
    m_ready = 1; cyc(2);
    chk("single_drain", fifo_level, 0);
    // backpressure: fill, then a fifth word must wait for a pop
    m_ready = 0;
    for (int i = 1; i <= 4; i++) xfer(8'(i));
    chk("bp_full", fifo_level, 4);
    data_in = 8'h05; do_rdy_in = 1; cyc(3);
    chk("bp_withheld", do_acpt_out, 0);
    m_ready = 1; cyc(1);
    m_ready = 0; cyc(2);
    chk("bp_late_cap", do_acpt_out, 1);
    do_rdy_in = 0; cyc(1);
    m_ready = 1; cyc(6);
    // long ready: one push only
    m_ready = 0; data_in = 8'($urandom); do_rdy_in = 1; cyc(20);
    chk("long_one_push", fifo_level, 1);
    do_rdy_in = 0; m_ready = 1; cyc(3);
    // push and pop together at level 2
    m_ready = 0;
    xfer(8'($urandom)); xfer(8'($urandom));
    data_in = 8'($urandom); do_rdy_in = 1; m_ready = 1; cyc(1);
    m_ready = 0; cyc(1);
    chk("pp_level", fifo_level, 2);
    do_rdy_in = 0; m_ready = 1; cyc(4);
    // reset during ACK with ready still high
    m_ready = 0; data_in = 8'h77; do_rdy_in = 1; cyc(2);
    rst = 1; cyc(1);
    chk("rst_mid_level", fifo_level, 0);
    rst = 0; cyc(2);
    chk("rst_recap", fifo_level, 1);
    do_rdy_in = 0; m_ready = 1; cyc(3);
    // random traffic; sender keeps data stable while ready is high
    for (int i = 0; i < 400; i++) begin
      if (!do_rdy_in && $urandom_range(0, 3) == 0) begin
        data_in = 8'($urandom); do_rdy_in = 1;
      end else if (do_rdy_in && (ack || wlow) && $urandom_range(0, 2) == 0) begin
        do_rdy_in = 0;
      end
      m_ready = 1'($urandom_range(0, 1));
      cyc(1);
    end
    do_rdy_in = 0; m_ready = 1; cyc(6);
`ifdef RX_SINK_TIMEOUT_EN
    rst = 1; cyc(1);
    rst = 0; cyc(1);
    data_in = 8'h5A; do_rdy_in = 1; cyc(TO + 2);
    chk("to_err", timeout_err, 1);
    chk("to_acpt", do_acpt_out, 0);
    cyc(3);
    do_rdy_in = 0; cyc(2);
    data_in = 8'h3C; do_rdy_in = 1; cyc(2);
    chk("to_recap", do_acpt_out, 1);
    do_rdy_in = 0; cyc(3);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
